envelope_follower: RTL

ENVELOPE_FOLLOWER -- requirements
Module: envelope_follower

---
 rtl/envelope_follower.sv | 127 ++++++++++++
 1 files changed

// File: rtl/envelope_follower.sv
// Multi-band envelope follower: one shared rectify/update datapath walks
// the bands of each accepted frame, then publishes all envelopes together.

package envelope_follower_pkg;
    localparam int N_FILTERS = 4;
    localparam int IDX_W     = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FILTERS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECTIFY = 2'd1,
        UPDATE  = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

module envelope_follower
    import envelope_follower_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               valid_in,
    input  logic [4:0]         attack_shift,
    input  logic [4:0]         release_shift,
    input  logic signed [31:0] band_channels     [N_FILTERS],
    output logic signed [31:0] envelope_channels [N_FILTERS],
    output logic               valid_out,
    output logic               busy_out
);

    // Magnitude with the single unrepresentable case (-2^31) clamped.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] x);
        logic [31:0] r;
        if (x == 32'sh8000_0000) begin
            r = 32'h7FFF_FFFF;
        end else if (x < 32'sd0) begin
            r = 32'(-x);
        end else begin
            r = 32'(x);
        end
        return r;
    endfunction

    state_t             state_q;
    logic [IDX_W-1:0]   index_q;
    logic signed [31:0] snap_q [N_FILTERS];
    logic [4:0]         attack_q;
    logic [4:0]         release_q;
    logic [31:0]        mag_q;
    logic signed [31:0] env_q  [N_FILTERS];

    logic [31:0]        mag_d;
    logic signed [32:0] diff_d;
    logic [4:0]         sh_d;
    logic signed [31:0] env_next_d;

    // Shared datapath: rectify the selected band and step its envelope.
    // Envelopes are never negative, so zero-extension to 33 bits is exact;
    // the sum lands between old env and mag, so truncation loses nothing.
    always_comb begin
        mag_d      = abs_sat(snap_q[index_q]);
        diff_d     = $signed({1'b0, mag_q}) - $signed({1'b0, env_q[index_q]});
        sh_d       = release_q;
        if (diff_d > 33'sd0) begin
            sh_d = attack_q;
        end else begin
            sh_d = release_q;
        end
        env_next_d = 32'($signed({1'b0, env_q[index_q]}) + (diff_d >>> sh_d));
    end

    // Frame sequencer: snapshot, per-band rectify/update, then publish.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            index_q   <= '0;
            attack_q  <= 5'd0;
            release_q <= 5'd0;
            mag_q     <= 32'd0;
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
            for (int i = 0; i < N_FILTERS; i++) begin
                snap_q[i]            <= 32'sd0;
                env_q[i]             <= 32'sd0;
                envelope_channels[i] <= 32'sd0;
            end
        end else begin
            valid_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        snap_q    <= band_channels;
                        attack_q  <= attack_shift;
                        release_q <= release_shift;
                        index_q   <= '0;
                        busy_out  <= 1'b1;
                        state_q   <= RECTIFY;
                    end else begin
                        busy_out  <= 1'b0;
                    end
                end
                RECTIFY: begin
                    mag_q   <= mag_d;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    env_q[index_q] <= env_next_d;
                    if (index_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        index_q <= index_q + IDX_W'(1);
                        state_q <= RECTIFY;
                    end
                end
                DONE: begin
                    envelope_channels <= env_q;
                    valid_out         <= 1'b1;
                    state_q           <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
